seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_pkg.sv | 38 +++
 rtl/seg7_decode.sv | 27 ++
 rtl/seg7_scan_driver.sv | 121 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 3-digit seven-segment scan driver: FSM states,
// active-low segment encodings and per-digit anode patterns.
package seg7_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  // Active-low segment patterns, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_ONES     = 4'b1110;
  localparam logic [3:0] AN_TENS     = 4'b1101;
  localparam logic [3:0] AN_HUNDREDS = 4'b1011;
  localparam logic [3:0] AN_OFF      = 4'b1111;

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] an;
    an = AN_OFF;
    case (idx)
      2'd0:    an = AN_ONES;
      2'd1:    an = AN_TENS;
      2'd2:    an = AN_HUNDREDS;
      default: an = AN_OFF;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern; non-decimal
// nibbles produce a blank digit.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Captures an 8-bit value, converts it to BCD by double-dabble and scans it
// over a 3-digit multiplexed display. Option: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] value_i,
  output logic       busy_o,
  output logic [3:0] an_o,
  output logic [6:0] seg_o
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  logic [0:0]  state, state_next;
  logic [2:0]  conv_cnt, conv_cnt_next;
  logic [19:0] shift_reg, shift_next, adjusted, shifted;
  logic [11:0] display, display_next;
  logic [15:0] scan_cnt, scan_cnt_next;
  logic [1:0]  digit_idx, digit_idx_next;
  logic [3:0]  an_next, sel_digit;
  logic [6:0]  seg_next, dec_seg;
  logic        blank;

  // Double-dabble step: add 3 to any BCD nibble >= 5, then shift left.
  always_comb begin
    adjusted = shift_reg;
    for (int i = 0; i < 3; i++) begin
      if (adjusted[8 + 4 * i +: 4] >= 4'd5) begin
        adjusted[8 + 4 * i +: 4] = adjusted[8 + 4 * i +: 4] + 4'd3;
      end
    end
    shifted = {adjusted[18:0], 1'b0};
  end

  always_comb begin
    state_next    = state;
    conv_cnt_next = conv_cnt;
    shift_next    = shift_reg;
    display_next  = display;
    case (state)
      IDLE: begin
        if (load_i) begin
          shift_next    = {12'd0, value_i};
          conv_cnt_next = 3'd0;
          state_next    = CONV;
        end
      end
      CONV: begin
        shift_next    = shifted;
        conv_cnt_next = conv_cnt + 3'd1;
        if (conv_cnt == 3'd7) begin
          state_next   = IDLE;
          display_next = shifted[19:8];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    if (scan_cnt == SCAN_LAST) begin
      scan_cnt_next  = 16'd0;
      digit_idx_next = digit_idx + 2'd1;
    end else begin
      scan_cnt_next  = scan_cnt + 16'd1;
      digit_idx_next = digit_idx;
    end
  end

  // Outputs are computed from next-state values so they register together
  // with the digit index and pick up a new result on the edge it lands.
  always_comb begin
    case (digit_idx_next)
      2'd0:    sel_digit = display_next[3:0];
      2'd1:    sel_digit = display_next[7:4];
      default: sel_digit = display_next[11:8];
    endcase
    blank = (digit_idx_next == 2'd3);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (digit_idx_next == 2'd2 && display_next[11:8] == 4'd0) blank = 1'b1;
    if (digit_idx_next == 2'd1 && display_next[11:4] == 8'd0) blank = 1'b1;
`endif
    seg_next = blank ? SEG_BLANK : dec_seg;
    an_next  = anode_for(digit_idx_next);
  end

  seg7_decode u_decode (
    .digit (sel_digit),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      conv_cnt  <= 3'd0;
      shift_reg <= 20'd0;
      display   <= 12'd0;
      scan_cnt  <= 16'd0;
      digit_idx <= 2'd0;
      an_o      <= AN_ONES;
      seg_o     <= SEG_0;
    end else begin
      state     <= state_next;
      conv_cnt  <= conv_cnt_next;
      shift_reg <= shift_next;
      display   <= display_next;
      scan_cnt  <= scan_cnt_next;
      digit_idx <= digit_idx_next;
      an_o      <= an_next;
      seg_o     <= seg_next;
    end
  end

  assign busy_o = (state == CONV);

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: loaded values are queued and checked
// against the scanned display once each conversion completes.
module tb_seg7_scan_driver;

  localparam int unsigned SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_i = 1'b0;
  logic [7:0] value_i = 8'd0;
  logic       busy_o;
  logic [3:0] an_o;
  logic [6:0] seg_o;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int shown = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_i),
    .value_i (value_i),
    .busy_o  (busy_o),
    .an_o    (an_o),
    .seg_o   (seg_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int idx);
    case (idx)
      0: return enc(v % 10);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      1: return (v < 10) ? 7'h7F : enc((v / 10) % 10);
      2: return (v < 100) ? 7'h7F : enc(v / 100);
`else
      1: return enc((v / 10) % 10);
      2: return enc(v / 100);
`endif
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [3:0] exp_an(input int idx);
    case (idx)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic int an_to_idx(input logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b1111: return 3;
      default: return -1;
    endcase
  endfunction

  // Called at a negedge; leaves the bench at the negedge after the load edge.
  task automatic start_load(input int v);
    load_i  = 1'b1;
    value_i = v[7:0];
    @(negedge clk);
    load_i = 1'b0;
    check("busy_rise", {31'd0, busy_o}, 32'd1);
    exp_q.push_back(v);
  endtask

  task automatic wait_done();
    int n;
    n = 1;
    while (busy_o === 1'b1 && n < 20) begin
      if (an_o == 4'b1110) check("hold_during_conv", {25'd0, seg_o}, {25'd0, exp_seg(shown, 0)});
      @(negedge clk);
      if (busy_o === 1'b1) n++;
    end
    check("busy_cycles", n, 8);
  endtask

  task automatic check_display();
    int v;
    int k;
    logic [6:0] seen[4];
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
      return;
    end
    v = exp_q.pop_front();
    for (int i = 0; i < 4; i++) seen[i] = 7'bx;
    repeat (4 * SCAN_DIV + 4) begin
      k = an_to_idx(an_o);
      if (k < 0) check("an_pattern", {28'd0, an_o}, 32'hE);
      else seen[k] = seg_o;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("seg_v%0d_d%0d", v, i), {25'd0, seen[i]}, {25'd0, exp_seg(v, i)});
    end
    shown = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_an", {28'd0, an_o}, 32'hE);
    check("reset_seg", {25'd0, seg_o}, 32'h40);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    reset = 1'b1;

    for (int k = 0; k < 20; k++) begin
      check($sformatf("scan_an_%0d", k), {28'd0, an_o}, {28'd0, exp_an((k / SCAN_DIV) % 4)});
      @(negedge clk);
    end

    start_load(225);
    wait_done();
    check_display();

    start_load(7);
    wait_done();
    check_display();

    // Second load arrives during the final conversion cycle and must be dropped.
    start_load(99);
    repeat (7) @(negedge clk);
    check("busy_before_last", {31'd0, busy_o}, 32'd1);
    load_i  = 1'b1;
    value_i = 8'd15;
    @(negedge clk);
    load_i = 1'b0;
    check("busy_after_ignored", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    check("busy_stays_low", {31'd0, busy_o}, 32'd0);
    check_display();

    start_load(42);
    wait_done();
    check_display();

    // Reset during CONV cycle 4 of a new conversion.
    start_load(200);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_an", {28'd0, an_o}, 32'hE);
    check("abort_seg", {25'd0, seg_o}, 32'h40);
    exp_q.delete();
    exp_q.push_back(0);
    @(negedge clk);
    reset = 1'b1;
    check("abort_no_restart", {31'd0, busy_o}, 32'd0);
    check_display();

    for (int v = 0; v < 256; v++) begin
      start_load(v);
      wait_done();
      check_display();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
